hex_display_mux: RTL

Time-multiplexed, parametrised hexadecimal display driver for the ALU result display. Latches a DIGITS-nibble value on a load strobe, commits it only at a scan-frame boundary (tear-free), and scans the digits one at a time onto shared active-low segment lines with per-digit active-low anodes. Adds registered outputs, anode dead-time, leading-zero suppression and decimal points to the team's single-digit hex decoder, while keeping the same font and Read-blanking semantics.

---
 rtl/hex_display_if.sv | 26 ++
 rtl/hex_display_mux.sv | 136 +++++++++++++
 2 files changed

// File: rtl/hex_display_if.sv
// Bus between the ALU result source and the multiplexed hex display driver.
// The source drives load/value/dp_in/read/lzs; the driver returns the pins and status.
interface hex_display_if #(
  parameter int DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     dp_in;
  logic                  read;
  logic                  lzs;
  logic [6:0]            seg;
  logic                  dp_n;
  logic [DIGITS-1:0]     an;
  logic                  pending;
  logic                  frame;

  modport master (
    output load, value, dp_in, read, lzs,
    input  seg, dp_n, an, pending, frame
  );

  modport slave (
    input  load, value, dp_in, read, lzs,
    output seg, dp_n, an, pending, frame
  );
endinterface

// File: rtl/hex_display_mux.sv
// Time-multiplexed hex display driver: tear-free frame commit, anode dead time,
// leading-zero suppression and decimal points on registered active-low outputs.
module hex_display_mux #(
  parameter int DIGITS = 4,
  parameter int DIV    = 1000
) (
  input logic         clk,
  input logic         rst,
  hex_display_if.slave bus
);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [PW-1:0]          pc;
  logic [IW-1:0]          idx;
  logic                   tick;
  logic                   boundary;
  logic [4*DIGITS-1:0]    disp_val;
  logic [4*DIGITS-1:0]    pend_val;
  logic [DIGITS-1:0]      disp_dp;
  logic [DIGITS-1:0]      pend_dp;

  logic [3:0]             nib;
  logic                   cur_dp;
  logic                   lead_zero;
  logic                   all_zero;
  logic [DIGITS-1:0]      an_sel;
  logic [6:0]             seg_next;
  logic                   dp_next;
  logic [DIGITS-1:0]      an_next;

  function automatic logic [6:0] hex_font(input logic [3:0] h);
    case (h)
      4'h0: hex_font = 7'h01;
      4'h1: hex_font = 7'h4F;
      4'h2: hex_font = 7'h12;
      4'h3: hex_font = 7'h06;
      4'h4: hex_font = 7'h4C;
      4'h5: hex_font = 7'h24;
      4'h6: hex_font = 7'h20;
      4'h7: hex_font = 7'h0F;
      4'h8: hex_font = 7'h00;
      4'h9: hex_font = 7'h0C;
      4'hA: hex_font = 7'h08;
      4'hB: hex_font = 7'h60;
      4'hC: hex_font = 7'h31;
      4'hD: hex_font = 7'h42;
      4'hE: hex_font = 7'h30;
      default: hex_font = 7'h38;
    endcase
  endfunction

  assign tick     = (pc == PW'(DIV - 1));
  assign boundary = tick && (idx == IW'(DIGITS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc  <= '0;
      idx <= '0;
    end else if (tick) begin
      pc  <= '0;
      idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      pc  <= pc + 1'b1;
    end
  end

  // A load in the boundary cycle bypasses the pending register so the newest value wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_val    <= '0;
      pend_dp     <= '0;
      disp_val    <= '0;
      disp_dp     <= '0;
      bus.pending <= 1'b0;
      bus.frame   <= 1'b0;
    end else begin
      bus.frame <= boundary;
      if (bus.load) begin
        pend_val <= bus.value;
        pend_dp  <= bus.dp_in;
      end
      if (boundary) begin
        bus.pending <= 1'b0;
        if (bus.load) begin
          disp_val <= bus.value;
          disp_dp  <= bus.dp_in;
        end else if (bus.pending) begin
          disp_val <= pend_val;
          disp_dp  <= pend_dp;
        end
      end else if (bus.load) begin
        bus.pending <= 1'b1;
      end
    end
  end

  // Walk from the top digit down so all_zero means "this nibble and everything above is 0".
  always_comb begin
    nib       = 4'h0;
    cur_dp    = 1'b0;
    lead_zero = 1'b0;
    all_zero  = 1'b1;
    an_sel    = '1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      all_zero = all_zero & (disp_val[4*i +: 4] == 4'h0);
      if (idx == IW'(i)) begin
        nib       = disp_val[4*i +: 4];
        cur_dp    = disp_dp[i];
        lead_zero = all_zero && (i != 0);
        an_sel[i] = 1'b0;
      end
    end

    seg_next = (bus.lzs && lead_zero) ? 7'h7F : hex_font(nib);
    dp_next  = ~cur_dp;
    an_next  = (pc == '0) ? '1 : an_sel;
    if (!bus.read) begin
      seg_next = 7'h7F;
      dp_next  = 1'b1;
      an_next  = '1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.seg  <= 7'h7F;
      bus.dp_n <= 1'b1;
      bus.an   <= '1;
    end else begin
      bus.seg  <= seg_next;
      bus.dp_n <= dp_next;
      bus.an   <= an_next;
    end
  end
endmodule
